util_gmii_slice_tap: RTL
========================

# util_gmii_slice_tap

Parametrised GMII slice that sits between a MAC-side GMII (S_GMII) and two PHY-side GMII endpoints: M_GMII_TX carries the transmit path and M_GMII_RX supplies the receive path. Both directions pass through a DELAY-stage register pipeline. A third, transmit-only monitor port (M_GMII_MON) mirrors either direction. Monitor enable and source changes are applied only at frame boundaries, and optional per-direction frame and error-frame counters are provided.

## Interface
- DELAY, 1, pipeline stages per direction; legal range 1..8.
- CNT_WIDTH, 32, width of each statistics counter; legal range 8..64.
- clk  in  1  sole clock for all logic.
- rst  in  1  synchronous reset, active-high. One clock; reset is synchronous and active-high.
- s_gmii_txd / s_gmii_tx_er / s_gmii_tx_en  in  8/1/1  MAC transmit data.
- s_gmii_rxd / s_gmii_rx_er / s_gmii_rx_dv  out  8/1/1  MAC receive data, taken from M_GMII_RX after the delay.
- m_gmii_tx_txd / m_gmii_tx_tx_er / m_gmii_tx_tx_en  out  8/1/1  delayed transmit data.
- m_gmii_tx_rxd / m_gmii_tx_rx_er / m_gmii_tx_rx_dv  in  8/1/1  ignored.
- m_gmii_rx_txd / m_gmii_rx_tx_er / m_gmii_rx_tx_en  out  8/1/1  constant 0.
- m_gmii_rx_rxd / m_gmii_rx_rx_er / m_gmii_rx_rx_dv  in  8/1/1  receive data source.
- m_gmii_mon_txd / m_gmii_mon_tx_er / m_gmii_mon_tx_en  out  8/1/1  monitor copy of the selected direction.
- mon_enable  in  1  requested monitor on/off.
- mon_sel  in  1  requested monitor source: 0 = TX, 1 = RX.
- mon_active  out  1  currently applied monitor enable.
- cnt_clear  in  1  synchronous clear of all counters.
- tx_frames, rx_frames, tx_err_frames, rx_err_frames  out  CNT_WIDTH  statistics counters.

## Operation
- TX pipeline: s_gmii_tx* passes through DELAY register stages to m_gmii_tx_*. RX pipeline: m_gmii_rx_* passes through DELAY register stages to s_gmii_rx*.
- "Last stage" means the final register of each pipeline. tx_busy = last-stage tx_en. rx_busy = last-stage rx_dv.
- Monitor control has two registers, act_en and act_sel, and two states:
  - OFF (act_en = 0): the monitor outputs are 0.
  - ON (act_en = 1): the monitor outputs equal the last stage of the act_sel direction. RX maps as rxd→txd, rx_er→tx_er, rx_dv→tx_en.
- Update rule: on each clock, if both tx_busy and rx_busy are 0 as seen by the currently monitored source and by the requested source, then act_en ← mon_enable and act_sel ← mon_sel. Otherwise both registers hold.
  - Consequence: a monitored frame is never truncated, and a frame is never started mid-stream on the monitor.
  - A request that is withdrawn before it applies is lost; the request is level-sampled, not latched.
- mon_active = act_en.
- Frame counting, per direction, on last-stage signals:
  - frames increments on the cycle where en goes 0→1 (previous last-stage en = 0, current = 1).
  - An error flag sets on any cycle with en = 1 and er = 1, and clears at the end of the frame.
  - err_frames increments on the cycle where en goes 1→0 while the error flag is set, including an error seen on the final en = 1 cycle.
- Counter arithmetic: unsigned, wraps modulo 2^CNT_WIDTH with no saturation.
- cnt_clear has priority. A counter whose increment coincides with cnt_clear becomes 1, not 0.

## Timing
- Data latency is exactly DELAY cycles from input to pass-through output, in both directions.
- The monitor output is cycle-aligned with m_gmii_tx_* or s_gmii_rx* (combinational mux on the last stage, no extra register).
- A control change sampled at edge t is visible on the monitor after edge t.
- Counters update on the edge that registers the qualifying last-stage transition and are visible 1 cycle after it.
- Reset values:
  - All pipeline stages, all outputs, act_en, act_sel, error flags and counters are 0.
  - m_gmii_rx_tx* is always 0.
- Reset asserted mid-frame: outputs are 0 from the next cycle, the frame is truncated and not counted as an error, and the monitor returns to OFF.
- After reset release, valid pass-through data appears DELAY cycles after the first input.

## Configuration
- UTIL_GMII_SLICE_TAP_COUNTERS_EN defined: the four counters, error flags and edge detection are compiled in.
- Macro undefined: the four counter outputs are tied to 0 and cnt_clear is ignored. Data paths and monitor behave identically in both builds.

## Test plan
- DELAY=3, a 64-byte TX frame with txd counting from 0x00 → m_gmii_tx_txd shows the same bytes exactly 3 cycles later, and tx_frames = 1.
- An RX frame with rx_er pulsed on byte 10 and mon_enable=1, mon_sel=1 applied while idle → the monitor carries the frame aligned with s_gmii_rx*, rx_err_frames = 1, and m_gmii_rx_tx* stays 0.
- mon_sel toggled 0→1 mid-TX-frame → the monitor finishes the TX frame intact and switches to RX on the first cycle both paths are idle.
- CNT_WIDTH=8, 257 TX frames → tx_frames = 1 (wraps). cnt_clear asserted on the same cycle as a frame start → tx_frames = 1.
- rst pulsed mid-frame → all outputs 0 on the next cycle, mon_active = 0, and no error frame is counted.
- Build without UTIL_GMII_SLICE_TAP_COUNTERS_EN and run 5 frames → all counters read 0 and data latency is unchanged.

Source files
------------

// File: rtl/util_gmii_slice_tap.sv
// util_gmii_slice_tap
//
// GMII slice placed between a MAC-side GMII and two PHY-side endpoints.
// The transmit path (MAC -> M_GMII_TX) and the receive path
// (M_GMII_RX -> MAC) each go through DELAY register stages. A transmit-only
// monitor port mirrors the last stage of either direction. Monitor on/off
// and source changes are applied only while both relevant paths are idle,
// so a mirrored frame is never cut short or picked up mid-stream.
//
// Optional feature macro: UTIL_GMII_SLICE_TAP_COUNTERS_EN
//   defined   : per-direction frame and error-frame counters are built in.
//   undefined : the counter outputs are tied to 0 and cnt_clear is ignored.
//
// Parameters
//   DELAY      pipeline stages per direction (1..8)
//   CNT_WIDTH  statistics counter width (8..64)
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   s_gmii_tx{d,_er,_en}       in     MAC transmit data
//   s_gmii_rx{d,_er,_dv}       out    MAC receive data (delayed M_GMII_RX)
//   m_gmii_tx_tx{d,_er,_en}    out    delayed transmit data
//   m_gmii_tx_rx{d,_er,_dv}    in     unused
//   m_gmii_rx_tx{d,_er,_en}    out    constant 0
//   m_gmii_rx_rx{d,_er,_dv}    in     receive data source
//   m_gmii_mon_tx{d,_er,_en}   out    monitor copy of the selected direction
//   mon_enable, mon_sel        in     requested monitor enable / source (0=TX, 1=RX)
//   mon_active                 out    currently applied monitor enable
//   cnt_clear                  in     synchronous clear of all counters
//   tx_frames, rx_frames,
//   tx_err_frames, rx_err_frames out  statistics counters

module util_gmii_slice_tap #(
  parameter int DELAY     = 1,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic [7:0]           s_gmii_txd,
  input  logic                 s_gmii_tx_er,
  input  logic                 s_gmii_tx_en,
  output logic [7:0]           s_gmii_rxd,
  output logic                 s_gmii_rx_er,
  output logic                 s_gmii_rx_dv,

  output logic [7:0]           m_gmii_tx_txd,
  output logic                 m_gmii_tx_tx_er,
  output logic                 m_gmii_tx_tx_en,
  input  logic [7:0]           m_gmii_tx_rxd,
  input  logic                 m_gmii_tx_rx_er,
  input  logic                 m_gmii_tx_rx_dv,

  output logic [7:0]           m_gmii_rx_txd,
  output logic                 m_gmii_rx_tx_er,
  output logic                 m_gmii_rx_tx_en,
  input  logic [7:0]           m_gmii_rx_rxd,
  input  logic                 m_gmii_rx_rx_er,
  input  logic                 m_gmii_rx_rx_dv,

  output logic [7:0]           m_gmii_mon_txd,
  output logic                 m_gmii_mon_tx_er,
  output logic                 m_gmii_mon_tx_en,

  input  logic                 mon_enable,
  input  logic                 mon_sel,
  output logic                 mon_active,

  input  logic                 cnt_clear,
  output logic [CNT_WIDTH-1:0] tx_frames,
  output logic [CNT_WIDTH-1:0] rx_frames,
  output logic [CNT_WIDTH-1:0] tx_err_frames,
  output logic [CNT_WIDTH-1:0] rx_err_frames
);

  // Each pipeline word is {en/dv, er, data}.
  localparam int WORD_W = 10;

  logic [DELAY-1:0][WORD_W-1:0] tx_pipe_reg;
  logic [DELAY-1:0][WORD_W-1:0] rx_pipe_reg;
  logic [WORD_W-1:0]            tx_last;
  logic [WORD_W-1:0]            rx_last;
  logic                         tx_busy;
  logic                         rx_busy;

  // ------------------------------------------------------------------
  // Data pipelines
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_pipe_reg <= '0;
      rx_pipe_reg <= '0;
    end else begin
      tx_pipe_reg[0] <= {s_gmii_tx_en, s_gmii_tx_er, s_gmii_txd};
      rx_pipe_reg[0] <= {m_gmii_rx_rx_dv, m_gmii_rx_rx_er, m_gmii_rx_rxd};
      for (int i = 1; i < DELAY; i++) begin
        tx_pipe_reg[i] <= tx_pipe_reg[i-1];
        rx_pipe_reg[i] <= rx_pipe_reg[i-1];
      end
    end
  end

  assign tx_last = tx_pipe_reg[DELAY-1];
  assign rx_last = rx_pipe_reg[DELAY-1];
  assign tx_busy = tx_last[9];
  assign rx_busy = rx_last[9];

  assign {m_gmii_tx_tx_en, m_gmii_tx_tx_er, m_gmii_tx_txd} = tx_last;
  assign {s_gmii_rx_dv, s_gmii_rx_er, s_gmii_rxd}          = rx_last;

  // The receive endpoint never gets transmit traffic from this slice.
  assign m_gmii_rx_txd   = 8'd0;
  assign m_gmii_rx_tx_er = 1'b0;
  assign m_gmii_rx_tx_en = 1'b0;

  // ------------------------------------------------------------------
  // Monitor control: state register / next-state / output
  // ------------------------------------------------------------------
  logic act_en_reg;
  logic act_sel_reg;
  logic act_en_next;
  logic act_sel_next;
  logic cur_busy;
  logic req_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      act_en_reg  <= 1'b0;
      act_sel_reg <= 1'b0;
    end else begin
      act_en_reg  <= act_en_next;
      act_sel_reg <= act_sel_next;
    end
  end

  // A change is allowed only when neither the source being mirrored now nor
  // the requested source is mid-frame. The request is sampled, not latched.
  assign cur_busy = act_sel_reg ? rx_busy : tx_busy;
  assign req_busy = mon_sel     ? rx_busy : tx_busy;

  always_comb begin
    act_en_next  = act_en_reg;
    act_sel_next = act_sel_reg;
    if (!cur_busy && !req_busy) begin
      act_en_next  = mon_enable;
      act_sel_next = mon_sel;
    end
  end

  // Combinational mux on the last stage keeps the monitor cycle-aligned
  // with the pass-through outputs.
  always_comb begin
    {m_gmii_mon_tx_en, m_gmii_mon_tx_er, m_gmii_mon_txd} = '0;
    if (act_en_reg) begin
      if (act_sel_reg) begin
        {m_gmii_mon_tx_en, m_gmii_mon_tx_er, m_gmii_mon_txd} = rx_last;
      end else begin
        {m_gmii_mon_tx_en, m_gmii_mon_tx_er, m_gmii_mon_txd} = tx_last;
      end
    end
  end

  assign mon_active = act_en_reg;

  // ------------------------------------------------------------------
  // Statistics
  // ------------------------------------------------------------------
`ifdef UTIL_GMII_SLICE_TAP_COUNTERS_EN
  // Index 0 = TX direction, index 1 = RX direction.
  logic [1:0]                last_en;
  logic [1:0]                last_er;
  logic [1:0][CNT_WIDTH-1:0] frames_w;
  logic [1:0][CNT_WIDTH-1:0] err_frames_w;

  assign last_en = {rx_busy, tx_busy};
  assign last_er = {rx_last[8], tx_last[8]};

  for (genvar gi = 0; gi < 2; gi++) begin : g_stats
    logic                 prev_en_reg;
    logic                 err_flag_reg;
    logic                 err_flag_next;
    logic [CNT_WIDTH-1:0] frames_reg;
    logic [CNT_WIDTH-1:0] err_frames_reg;
    logic                 frame_start;
    logic                 frame_end;
    logic                 err_end;
    logic [CNT_WIDTH-1:0] frames_inc;
    logic [CNT_WIDTH-1:0] err_inc;

    assign frame_start = last_en[gi] & ~prev_en_reg;
    assign frame_end   = ~last_en[gi] & prev_en_reg;
    // The flag is registered, so an error on the final en=1 cycle is
    // already visible here when the falling edge is detected.
    assign err_end     = frame_end & err_flag_reg;
    assign frames_inc  = {{(CNT_WIDTH-1){1'b0}}, frame_start};
    assign err_inc     = {{(CNT_WIDTH-1){1'b0}}, err_end};

    always_comb begin
      err_flag_next = err_flag_reg;
      if (frame_end) begin
        err_flag_next = 1'b0;
      end
      if (last_en[gi] && last_er[gi]) begin
        err_flag_next = 1'b1;
      end
    end

    // A clear coinciding with an increment leaves the counter at 1.
    always_ff @(posedge clk) begin
      if (rst) begin
        prev_en_reg    <= 1'b0;
        err_flag_reg   <= 1'b0;
        frames_reg     <= '0;
        err_frames_reg <= '0;
      end else begin
        prev_en_reg  <= last_en[gi];
        err_flag_reg <= err_flag_next;
        if (cnt_clear) begin
          frames_reg     <= frames_inc;
          err_frames_reg <= err_inc;
        end else begin
          frames_reg     <= frames_reg + frames_inc;
          err_frames_reg <= err_frames_reg + err_inc;
        end
      end
    end

    assign frames_w[gi]     = frames_reg;
    assign err_frames_w[gi] = err_frames_reg;
  end

  assign tx_frames     = frames_w[0];
  assign rx_frames     = frames_w[1];
  assign tx_err_frames = err_frames_w[0];
  assign rx_err_frames = err_frames_w[1];
`else
  logic unused_cnt_clear;
  assign unused_cnt_clear = cnt_clear;

  assign tx_frames     = '0;
  assign rx_frames     = '0;
  assign tx_err_frames = '0;
  assign rx_err_frames = '0;
`endif

  // Receive side of the transmit endpoint carries nothing we use.
  logic unused_tx_rx;
  assign unused_tx_rx = &{1'b0, m_gmii_tx_rxd, m_gmii_tx_rx_er, m_gmii_tx_rx_dv};

endmodule
